// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset/NOP values,
// fetch FSM states and the IF/ID output record.
package if_fetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_NOP_INST = 32'h0000_0013;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] now_pc;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] advance_pc;
    } ifid_out_t;

    // Instructions are word aligned; the low two target bits are simply dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

    function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus: one-outstanding req/gnt/rvalid handshake.
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/if_fetch_unit_pc_reg.sv
// Program counter register: loads an aligned redirect target or steps by 4 after
// each accepted instruction; redirect always wins.
module if_fetch_unit_pc_reg
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            advance_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = align_pc(redirect_pc_i);
        end else if (advance_i) begin
            pc_d = next_seq_pc(pc_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= align_pc(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = next_seq_pc(pc_q);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the one-outstanding imem handshake and
// presents {now_pc, inst, advance_pc, valid} to IF/ID, honouring stall and EX redirect.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    if_fetch_unit_if.master    imem,
    output logic               valid_o,
    output logic [XLEN-1:0]    now_pc_o,
    output logic [XLEN-1:0]    inst_o,
    output logic [XLEN-1:0]    advance_pc_o
);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic            kill_q;
    logic            kill_d;
    ifid_out_t       out_q;
    ifid_out_t       out_d;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            can_issue;
    logic            req;
    logic            granted;
    logic            rsp_fire;
    logic            capture;

    if_fetch_unit_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .advance_i     (capture),
        .pc_o          (pc),
        .pc_plus4_o    (pc_plus4)
    );

    // A new fetch is only issued when the held instruction will leave this cycle.
    always_comb begin
        can_issue = !out_q.valid || !stall_i;
        req       = rst_n && (state_q == S_REQ) && can_issue;
        granted   = req && imem.gnt;
        rsp_fire  = (state_q == S_WAIT) && imem.rvalid;
        capture   = rsp_fire && !kill_q && !redirect_i;
    end

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        case (state_q)
            S_REQ: begin
                if (granted) begin
                    state_d = S_WAIT;
                    kill_d  = redirect_i;
                end
            end
            S_WAIT: begin
                if (rsp_fire) begin
                    state_d = S_REQ;
                    kill_d  = 1'b0;
                end else if (redirect_i) begin
                    kill_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_REQ;
                kill_d  = 1'b0;
            end
        endcase
    end

    // Redirect flushes even under stall; otherwise a stalled valid holds bit-exact.
    always_comb begin
        out_d = out_q;
        if (redirect_i) begin
            out_d.valid = 1'b0;
            out_d.inst  = NOP_INST;
        end else if (capture) begin
            out_d.valid      = 1'b1;
            out_d.now_pc     = pc;
            out_d.inst       = imem.rdata;
            out_d.advance_pc = pc_plus4;
        end else if (out_q.valid && !stall_i) begin
            out_d.valid = 1'b0;
            out_d.inst  = NOP_INST;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_REQ;
            kill_q           <= 1'b0;
            out_q.valid      <= 1'b0;
            out_q.now_pc     <= '0;
            out_q.inst       <= NOP_INST;
            out_q.advance_pc <= '0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            out_q   <= out_d;
        end
    end

    assign imem.req     = req;
    assign imem.addr    = pc;
    assign valid_o      = out_q.valid;
    assign now_pc_o     = out_q.now_pc;
    assign inst_o       = out_q.inst;
    assign advance_pc_o = out_q.advance_pc;

    // A response with nothing outstanding is a memory protocol error.
    a_no_stray_rvalid: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(imem.rvalid && state_q == S_REQ)
    );

    a_req_held_until_gnt: assert property (
        @(posedge clk) disable iff (!rst_n)
        (req && !imem.gnt && !redirect_i) |=> (req && $stable(imem.addr))
    );

endmodule
